// File: rtl/bc_polinomio.sv
// Control block for the 16-bit polynomial datapath.
// Sequences one Horner evaluation s = ((a*x) + b)*x + c over five busy cycles,
// then holds pronto until the 4-phase inicio handshake is closed.
// Moore machine: every output is a pure decode of the state register.

module bc_polinomio (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       h,
    output logic       pronto,
    output logic       ocupado
);

    // Constant mux selects (m0)
    localparam logic [1:0] KZero = 2'd0;
    localparam logic [1:0] KA    = 2'd1;
    localparam logic [1:0] KB    = 2'd2;
    localparam logic [1:0] KC    = 2'd3;

    // Operand-B mux selects (m1)
    localparam logic [1:0] BConst = 2'd0;
    localparam logic [1:0] BXReg  = 2'd1;

    // Operand-A mux selects (m2)
    localparam logic [1:0] AXReg  = 2'd0;
    localparam logic [1:0] AConst = 2'd1;
    localparam logic [1:0] ASReg  = 2'd2;

    // ULA operations
    localparam logic OpAdd = 1'b0;
    localparam logic OpMul = 1'b1;

    // Encoding 3'd7 is unused and falls back to StIdle
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCarregaX = 3'd1,
        StMulA     = 3'd2,
        StSomaB    = 3'd3,
        StMulX     = 3'd4,
        StSomaC    = 3'd5,
        StPronto   = 3'd6
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register; reset forces IDLE without waiting for a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; inicio only matters in IDLE and PRONTO
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:     state_d = inicio ? StCarregaX : StIdle;
            StCarregaX: state_d = StMulA;
            StMulA:     state_d = StSomaB;
            StSomaB:    state_d = StMulX;
            StMulX:     state_d = StSomaC;
            StSomaC:    state_d = StPronto;
            StPronto:   state_d = inicio ? StPronto : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output decode from state only; lh stays low since h reg is never used
    always_comb begin
        m0      = KZero;
        m1      = BConst;
        m2      = AXReg;
        lx      = 1'b0;
        ls      = 1'b0;
        lh      = 1'b0;
        h       = OpAdd;
        pronto  = 1'b0;
        ocupado = 1'b0;
        case (state_q)
            StCarregaX: begin
                lx      = 1'b1;
                ocupado = 1'b1;
            end
            StMulA: begin
                // s <= a * x
                m0      = KA;
                m2      = AConst;
                m1      = BXReg;
                h       = OpMul;
                ls      = 1'b1;
                ocupado = 1'b1;
            end
            StSomaB: begin
                // s <= s + b
                m2      = ASReg;
                m0      = KB;
                m1      = BConst;
                h       = OpAdd;
                ls      = 1'b1;
                ocupado = 1'b1;
            end
            StMulX: begin
                // s <= s * x
                m2      = ASReg;
                m1      = BXReg;
                h       = OpMul;
                ls      = 1'b1;
                ocupado = 1'b1;
            end
            StSomaC: begin
                // s <= s + c
                m2      = ASReg;
                m0      = KC;
                m1      = BConst;
                h       = OpAdd;
                ls      = 1'b1;
                ocupado = 1'b1;
            end
            StPronto: begin
                pronto = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
